// File: rtl/mul_operand_sched.sv
// Operand scheduler for the serial shift-add multiplier. Operand pairs are queued in a
// small FIFO and issued one at a time. Each result, or a watchdog timeout, goes out on a
// valid/ready port.
module mul_operand_sched #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [W-1:0]             in_a_i,
  input  logic [W-1:0]             in_b_i,
  output logic                     mul_start_o,
  output logic [W-1:0]             mul_a_o,
  output logic [W-1:0]             mul_b_o,
  input  logic                     mul_done_i,
  input  logic [W-1:0]             mul_y_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [W-1:0]             out_y_o,
  output logic                     out_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  // state | meaning
  // IDLE  | waiting for a queued pair and a free output slot
  // ISSUE | start pulse to the multiplier, timer cleared
  // WAIT  | multiplication in flight, watchdog running
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  logic push, pop, slot_free, load_ok, load_err;

  assign in_ready_o  = rst_i & (count < CW'(DEPTH));
  assign push        = in_valid_i & in_ready_o;
  assign slot_free   = ~out_valid_o | out_ready_i;
  assign count_o     = count;
  assign mul_start_o = (state == ISSUE);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= in_a_i;
        mem_b[wr_ptr] <= in_b_i;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_ok    = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && slot_free) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        // A done in the same cycle as the timeout still counts as a good result.
        if (mul_done_i) begin
          load_ok    = 1'b1;
          state_next = IDLE;
        end else if (timer == TW'(TMO - 1)) begin
          load_err   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT) begin
      timer <= timer + TW'(1);
    end
  end

  // Operands only move on the IDLE->ISSUE edge and stay put through WAIT.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mul_a_o <= '0;
      mul_b_o <= '0;
    end else if (pop) begin
      mul_a_o <= mem_a[rd_ptr];
      mul_b_o <= mem_b[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid_o <= 1'b0;
      out_y_o     <= '0;
      out_err_o   <= 1'b0;
    end else if (load_ok) begin
      out_valid_o <= 1'b1;
      out_y_o     <= mul_y_i;
      out_err_o   <= 1'b0;
    end else if (load_err) begin
      out_valid_o <= 1'b1;
      out_y_o     <= '0;
      out_err_o   <= 1'b1;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
      out_y_o     <= '0;
      out_err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_operand_sched.sv
// Bench for mul_operand_sched: directed scenarios followed by random traffic, checked
// against a queue model of the operand stream plus a behavioural multiplier.
module tb_mul_operand_sched;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic                   clk_i;
  logic                   rst_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [W-1:0]           in_a_i;
  logic [W-1:0]           in_b_i;
  logic                   mul_start_o;
  logic [W-1:0]           mul_a_o;
  logic [W-1:0]           mul_b_o;
  logic                   mul_done_i;
  logic [W-1:0]           mul_y_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [W-1:0]           out_y_o;
  logic                   out_err_o;
  logic [$clog2(DEPTH):0] count_o;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  typedef struct packed {
    logic [W-1:0] y;
    logic         err;
  } res_t;

  pair_t pend_q[$];
  res_t  res_q[$];

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  int n_results = 0;
  int mpend = -1;
  int lat_force = -1;
  int since_start = 0;
  int rdy_mode = 1;
  bit mdl_drive = 1'b1;
  bit have_issued = 1'b0;
  bit start_seen = 1'b0;
  logic [W-1:0] cur_a, cur_b, last_y;
  logic         last_err;

  mul_operand_sched #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .mul_start_o (mul_start_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_done_i  (mul_done_i),
    .mul_y_i     (mul_y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_y_o     (out_y_o),
    .out_err_o   (out_err_o),
    .count_o     (count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiplier latency in cycles after the start pulse; 0 means it never finishes.
  function automatic int lat_of(pair_t p);
    if (lat_force >= 0) return lat_force;
    if (p.a[3:0] == 4'hF) return 0;
    return 1 + int'(p.b % 16'd20);
  endfunction

  function automatic res_t expect_of(pair_t p, int lat);
    logic [2*W-1:0] full;
    res_t r;
    full = p.a * p.b;
    if (lat == 0 || lat > TMO) begin
      r.y   = '0;
      r.err = 1'b1;
    end else begin
      r.y   = full[W-1:0];
      r.err = 1'b0;
    end
    return r;
  endfunction

  // One clock: handshakes are recorded at the falling edge, the DUT is observed 1ns
  // after the rising edge, then the multiplier model and consumer update their inputs.
  task automatic tick();
    pair_t p;
    res_t  r;
    int    lat;
    @(negedge clk_i);
    if (!rst_i) begin
      pend_q.delete();
      res_q.delete();
      have_issued = 1'b0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        p.a = in_a_i;
        p.b = in_b_i;
        pend_q.push_back(p);
      end
      if (out_valid_o && out_ready_i) begin
        n_results++;
        if (res_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid_o), 32'd0);
        end else begin
          r = res_q.pop_front();
          chk("res_y", 32'(out_y_o), 32'(r.y));
          chk("res_err", 32'(out_err_o), 32'(r.err));
        end
        last_y   = out_y_o;
        last_err = out_err_o;
      end
    end
    @(posedge clk_i);
    #1;
    if (mdl_drive && mul_done_i) begin
      mul_done_i = 1'b0;
      mul_y_i    = W'($urandom);
    end
    start_seen = mul_start_o;
    if (mul_start_o) begin
      n_starts++;
      since_start = 0;
      if (pend_q.size() == 0) begin
        chk("spurious_start", 32'(mul_start_o), 32'd0);
      end else begin
        p = pend_q.pop_front();
        chk("start_a", 32'(mul_a_o), 32'(p.a));
        chk("start_b", 32'(mul_b_o), 32'(p.b));
        cur_a = p.a;
        cur_b = p.b;
        have_issued = 1'b1;
        lat = lat_of(p);
        res_q.push_back(expect_of(p, lat));
        mpend = (lat == 0) ? -1 : lat;
      end
    end else begin
      since_start++;
      if (mpend > 0) begin
        mpend--;
        if (mpend == 0) begin
          mpend = -1;
          if (mdl_drive) begin
            mul_done_i = 1'b1;
            mul_y_i    = cur_a * cur_b;
          end
        end
      end
      if (have_issued) begin
        chk("hold_a", 32'(mul_a_o), 32'(cur_a));
        chk("hold_b", 32'(mul_b_o), 32'(cur_b));
      end
    end
    if (rst_i) begin
      chk("count", 32'(count_o), 32'(pend_q.size()));
      chk("in_ready", 32'(in_ready_o), 32'(pend_q.size() < DEPTH));
    end
    case (rdy_mode)
      0:       out_ready_i = 1'b0;
      1:       out_ready_i = 1'b1;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic wait_start(input string tag, input int max);
    int k = 0;
    start_seen = 1'b0;
    while (!start_seen && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(start_seen), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!out_valid_o && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(out_valid_o), 32'd1);
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    in_valid_i = 1'b0;
    rdy_mode   = 1;
    mdl_drive  = 1'b1;
    while ((pend_q.size() != 0 || res_q.size() != 0) && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(pend_q.size() + res_q.size()), 32'd0);
  endtask

  task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    tick();
    in_valid_i = 1'b0;
  endtask

  initial begin
    int s0, r0;
    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    in_a_i      = '0;
    in_b_i      = '0;
    mul_done_i  = 1'b0;
    mul_y_i     = '0;
    out_ready_i = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_start", 32'(mul_start_o), 32'd0);
    chk("rst_mul_a", 32'(mul_a_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_err", 32'(out_err_o), 32'd0);
    rst_i = 1'b1;
    tick();
    chk("rst_release_ready", 32'(in_ready_o), 32'd1);

    // single pair, done 17 cycles after start
    lat_force = 17;
    s0 = n_starts;
    push1(16'd3, 16'd5);
    chk("t1_no_early_start", 32'(mul_start_o), 32'd0);
    tick();
    chk("t1_start_lat", 32'(mul_start_o), 32'd1);
    tick();
    chk("t1_pulse", 32'(mul_start_o), 32'd0);
    rdy_mode = 0;
    wait_valid("t1_valid", 40);
    chk("t1_done_lat", 32'(since_start), 32'd18);
    chk("t1_y", 32'(out_y_o), 32'd15);
    chk("t1_err", 32'(out_err_o), 32'd0);
    drain("t1_drain", 50);
    chk("t1_one_start", 32'(n_starts - s0), 32'd1);

    // four back-to-back pushes, consumer stalled
    rdy_mode    = 0;
    out_ready_i = 1'b0;
    lat_force   = 5;
    s0 = n_starts;
    r0 = n_results;
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a_i = W'(2 * i + 1);
      in_b_i = W'(2 * i + 2);
      tick();
    end
    in_valid_i = 1'b0;
    chk("t2_count3", 32'(count_o), 32'd3);
    repeat (20) tick();
    chk("t2_held_valid", 32'(out_valid_o), 32'd1);
    chk("t2_held_y", 32'(out_y_o), 32'd2);
    chk("t2_no_second_start", 32'(n_starts - s0), 32'd1);
    in_valid_i = 1'b1;
    in_a_i = 16'd9;
    in_b_i = 16'd10;
    tick();
    in_a_i = 16'd11;
    in_b_i = 16'd12;
    chk("t2_full_count", 32'(count_o), 32'd4);
    chk("t2_full_ready", 32'(in_ready_o), 32'd0);
    tick();
    tick();

    // full FIFO with a pop in the same cycle: no push
    rdy_mode    = 1;
    out_ready_i = 1'b1;
    tick();
    chk("t3_no_push_on_pop", 32'(count_o), 32'd3);
    chk("t3_second_start", 32'(n_starts - s0), 32'd2);
    tick();
    in_valid_i = 1'b0;
    drain("t3_drain", 300);
    chk("t3_results", 32'(n_results - r0), 32'd6);

    // watchdog timeout, then the next queued pair issues
    rdy_mode    = 0;
    out_ready_i = 1'b0;
    lat_force   = 0;
    in_valid_i  = 1'b1;
    in_a_i = 16'd13;
    in_b_i = 16'd14;
    tick();
    in_a_i = 16'd15;
    in_b_i = 16'd16;
    tick();
    in_valid_i = 1'b0;
    wait_valid("t4_valid", 100);
    chk("t4_tmo_lat", 32'(since_start), 32'd65);
    chk("t4_err", 32'(out_err_o), 32'd1);
    chk("t4_y", 32'(out_y_o), 32'd0);
    lat_force   = 3;
    rdy_mode    = 1;
    out_ready_i = 1'b1;
    wait_start("t4_next_start", 10);
    chk("t4_next_a", 32'(mul_a_o), 32'd15);
    drain("t4_drain", 100);

    // done on the last watchdog cycle wins; one cycle later is a timeout
    lat_force = 64;
    push1(16'd2, 16'd3);
    drain("t4_lat64_drain", 200);
    chk("t4_lat64_y", 32'(last_y), 32'd6);
    chk("t4_lat64_err", 32'(last_err), 32'd0);
    lat_force = 65;
    push1(16'd4, 16'd5);
    drain("t4_lat65_drain", 200);
    chk("t4_lat65_y", 32'(last_y), 32'd0);
    chk("t4_lat65_err", 32'(last_err), 32'd1);
    repeat (5) tick();

    // reset during WAIT, then a stale done
    lat_force = 10;
    r0 = n_results;
    push1(16'd7, 16'd7);
    wait_start("t5_start", 5);
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_in_ready", 32'(in_ready_o), 32'd0);
    chk("t5_out_valid", 32'(out_valid_o), 32'd0);
    chk("t5_start", 32'(mul_start_o), 32'd0);
    chk("t5_mul_a", 32'(mul_a_o), 32'd0);
    chk("t5_mul_b", 32'(mul_b_o), 32'd0);
    chk("t5_out_y", 32'(out_y_o), 32'd0);
    chk("t5_out_err", 32'(out_err_o), 32'd0);
    rst_i = 1'b1;
    tick();
    chk("t5_release_ready", 32'(in_ready_o), 32'd1);
    repeat (15) tick();
    chk("t5_no_result", 32'(n_results - r0), 32'd0);
    chk("t5_still_idle", 32'(out_valid_o), 32'd0);

    // done held high through IDLE and ISSUE
    mdl_drive   = 1'b0;
    lat_force   = 1;
    rdy_mode    = 0;
    out_ready_i = 1'b0;
    mul_done_i  = 1'b1;
    mul_y_i     = 16'h0BAD;
    repeat (3) tick();
    chk("t6_idle_ignored", 32'(out_valid_o), 32'd0);
    push1(16'd6, 16'd7);
    tick();
    chk("t6_start", 32'(mul_start_o), 32'd1);
    tick();
    chk("t6_issue_ignored", 32'(out_valid_o), 32'd0);
    mul_y_i = 16'd42;
    tick();
    chk("t6_valid", 32'(out_valid_o), 32'd1);
    chk("t6_y", 32'(out_y_o), 32'd42);
    mul_done_i  = 1'b0;
    out_ready_i = 1'b1;
    drain("t6_drain", 20);

    // random traffic
    lat_force = -1;
    rdy_mode  = 2;
    s0 = n_starts;
    r0 = n_results;
    for (int i = 0; i < 800; i++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      in_a_i     = W'($urandom);
      in_b_i     = W'($urandom);
      tick();
    end
    drain("rand_drain", 3000);
    chk("rand_balance", 32'(n_results - r0), 32'(n_starts - s0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
